load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  Memory stage downstream of Datapath. Takes the registered effective address, funct3 and store
//  operand for RISC-V LOAD/STORE and runs one req/ack transaction on the word-wide data bus.
//  Aligns byte/half lanes, sign/zero-extends load results, flags misaligned or illegal accesses.
//  Returns load data to register write-back with a one-cycle done pulse.
// PARAMETERS
//  TIMEOUT   255  cycles waited for bus_ack before aborting with bus_err (8-bit counter)
// PORTS
//  clk         in   1   clock, rising edge
//  rst         in   1   reset, asynchronous, active-high
//  start       in   1   launch access; sampled only in IDLE
//  is_store    in   1   1=STORE (opcode 0100011), 0=LOAD (0000011)
//  funct3      in   3   width/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
//  mem_addr    in   32  byte effective address
//  store_data  in   32  rs2 value, low bits used for SB/SH
//  bus_req     out  1   request, held until ack
//  bus_we      out  1   write enable
//  bus_addr    out  32  word address {mem_addr[31:2],2'b00}
//  bus_wstrb   out  4   byte enables (writes and reads)
//  bus_wdata   out  32  lane-shifted store data
//  bus_rdata   in   32  read word, valid with bus_ack
//  bus_ack     in   1   one-cycle completion strobe
//  load_data   out  32  extended load result, valid with done
//  done        out  1   one-cycle pulse at completion (load, store or error)
//  busy        out  1   high in every state except IDLE
//  misaligned  out  1   error cause: alignment/illegal funct3, valid with done
//  bus_err     out  1   error cause: ack timeout, valid with done
// BEHAVIOUR
//  - Reset: state=IDLE; every output 0; timeout counter 0.
//  - FSM: IDLE -> REQ on start (legal, aligned) | IDLE -> ERR on start (illegal/misaligned);
//    REQ -> DONE on bus_ack | REQ -> ERR when counter reaches TIMEOUT; DONE -> IDLE; ERR -> IDLE.
//  - Capture: on accepted start, latch addr, funct3, is_store, store_data; bus outputs registered
//    from these, bus_req=1 from the cycle after start.
//  - Latency: start at cycle 0, ack at cycle N>=1 -> done=1 at cycle N+1; min 2 cycles.
//  - Handshake: bus_req/we/addr/wstrb/wdata stable while in REQ; bus_req drops in the cycle after
//    ack. Ack outside REQ ignored. start while busy ignored (not queued).
//  - Strobes: B -> 4'b0001<<a[1:0]; H -> 4'b0011<<a[1:0]; W -> 4'b1111 (a=mem_addr).
//  - Store data: B replicated {4{d[7:0]}}; H {2{d[15:0]}}; W d.
//  - Load: lane = rdata>>(8*a[1:0]); LB/LH sign-extend bit 7/15; LBU/LHU zero-extend; LW as is.
//    Captured on ack; load_data holds until next done. Stores leave load_data unchanged.
//  - Misaligned: H with a[0]=1; W with a[1:0]!=0. Illegal: load funct3 011/110/111, store
//    funct3 >=011. Either -> no bus cycle, ERR: done=1, misaligned=1, cycle after start.
//  - Timeout: counter counts REQ cycles without ack, cleared on entry to REQ; at TIMEOUT:
//    bus_req=0, done=1, bus_err=1. Ack arriving same cycle as timeout wins (normal DONE).
//  - misaligned/bus_err are 1 only with done, else 0.
//  - Reset mid-transaction: bus_req and done drop immediately (async), no completion reported.
// STRUCTURE
//  - lsu_pkg: funct3 constants F3_B/H/W/BU/HU, opcode constants OP_LOAD/OP_STORE,
//    state enum {IDLE,REQ,DONE,ERR}, function strobe(funct3,addr).
//  - Sub-module lsu_lane_align (combinational): store lane replication + load extract/extend.
//  - Top: FSM, capture regs, timeout counter, output regs.
// TESTING
//  1 SW addr 0x100, data 0xDEADBEEF, ack after 3 cycles -> bus_addr 0x100, wstrb 1111,
//    wdata 0xDEADBEEF, done on cycle 4, misaligned=0, bus_err=0.
//  2 LB addr 0x203, rdata 0x80FF_1234 -> wstrb 1000, load_data 0xFFFFFF80;
//    LBU same access -> 0x00000080.
//  3 SH addr 0x42, data 0x0000ABCD -> wstrb 1100, wdata 0xABCDABCD; LH addr 0x41 -> no bus_req,
//    done+misaligned the cycle after start.
//  4 LW, no ack for TIMEOUT cycles -> bus_req drops, done+bus_err; ack issued on the timeout
//    cycle -> normal done, bus_err=0.
//  5 start pulsed in REQ -> ignored, one transaction only; rst asserted in REQ -> bus_req=0
//    same cycle, no done.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit.
// funct3 codes, opcodes, FSM states and lane strobe logic.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DONE,
    ERR
  } state_t;

  function automatic logic [3:0] strobe(
    input logic [2:0] f3,
    input logic [1:0] a
  );
    logic [3:0] s;
    unique case (f3[1:0])
      2'b00:   s = 4'b0001 << a;
      2'b01:   s = 4'b0011 << a;
      default: s = 4'b1111;
    endcase
    return s;
  endfunction

  // Loads accept B/H/W/BU/HU, stores only B/H/W; H and W need natural alignment.
  function automatic logic access_ok(
    input logic       st,
    input logic [2:0] f3,
    input logic [1:0] a
  );
    logic r;
    unique case (1'b1)
      (f3 == F3_B):  r = 1'b1;
      (f3 == F3_H):  r = !a[0];
      (f3 == F3_W):  r = (a == 2'b00);
      (f3 == F3_BU): r = !st;
      (f3 == F3_HU): r = !st && !a[0];
      default:       r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/lsu_bus_if.sv
// Word-wide req/ack data bus between the LSU and memory.
// master = LSU side, slave = memory side.
interface lsu_bus_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  wstrb;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ack;

  modport master (
    output req, we, addr, wstrb, wdata,
    input  rdata, ack
  );

  modport slave (
    input  req, we, addr, wstrb, wdata,
    output rdata, ack
  );
endinterface

// File: rtl/lsu_lane_align.sv
// Lane alignment: store byte/half replication and
// load lane extraction with sign/zero extension.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  lane,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [31:0] wdata,
  output logic [31:0] load_val
);

  logic [31:0] shifted;

  assign shifted = rdata >> {lane, 3'b000};

  always_comb begin
    wdata    = store_data;
    load_val = shifted;
    unique case (1'b1)
      (funct3 == F3_B): begin
        wdata    = {4{store_data[7:0]}};
        load_val = {{24{shifted[7]}}, shifted[7:0]};
      end
      (funct3 == F3_H): begin
        wdata    = {2{store_data[15:0]}};
        load_val = {{16{shifted[15]}}, shifted[15:0]};
      end
      (funct3 == F3_BU): begin
        load_val = {24'b0, shifted[7:0]};
      end
      (funct3 == F3_HU): begin
        load_val = {16'b0, shifted[15:0]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory stage: one req/ack bus transaction per LOAD/STORE,
// with alignment checks, ack timeout and load extension.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] mem_addr,
  input  logic [31:0] store_data,
  lsu_bus_if.master   bus,
  output logic [31:0] load_data,
  output logic        done,
  output logic        busy,
  output logic        misaligned,
  output logic        bus_err
);

  state_t      state;
  state_t      state_nx;
  logic [7:0]  cnt;
  logic        accept;
  logic        ok;
  logic        tmo;
  logic        we_q;
  logic        mis_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q;
  logic [31:0] sdata_q;
  logic [3:0]  strb_q;
  logic [31:0] ld_q;
  logic [31:0] wdata;
  logic [31:0] ld_val;

  assign accept = (state == IDLE) && start;
  assign ok     = access_ok(is_store, funct3, mem_addr[1:0]);
  assign tmo    = (cnt == 8'(TIMEOUT - 1));

  lsu_lane_align u_align (
    .funct3     (f3_q),
    .lane       (addr_q[1:0]),
    .store_data (sdata_q),
    .rdata      (bus.rdata),
    .wdata      (wdata),
    .load_val   (ld_val)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (start) state_nx = ok ? REQ : ERR;
      end
      REQ: begin
        // ack beats a timeout landing in the same cycle
        if (bus.ack)  state_nx = DONE;
        else if (tmo) state_nx = ERR;
      end
      DONE:    state_nx = IDLE;
      ERR:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    bus.req    = (state == REQ);
    busy       = (state != IDLE);
    done       = (state == DONE) || (state == ERR);
    misaligned = (state == ERR) && mis_q;
    bus_err    = (state == ERR) && !mis_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (state == IDLE) begin
      cnt <= '0;
    end else if (state == REQ && !bus.ack) begin
      cnt <= cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q    <= 1'b0;
      mis_q   <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      sdata_q <= '0;
      strb_q  <= '0;
    end else if (accept) begin
      we_q    <= is_store;
      mis_q   <= !ok;
      f3_q    <= funct3;
      addr_q  <= mem_addr;
      sdata_q <= store_data;
      strb_q  <= strobe(funct3, mem_addr[1:0]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ld_q <= '0;
    end else if (state == REQ && bus.ack && !we_q) begin
      ld_q <= ld_val;
    end
  end

  assign bus.we    = we_q;
  assign bus.addr  = {addr_q[31:2], 2'b00};
  assign bus.wstrb = strb_q;
  assign bus.wdata = wdata;
  assign load_data = ld_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit against a
// byte-arithmetic model of the access rules.
module tb_load_store_unit;

  localparam int TMO = 255;

  logic        clk;
  logic        rst;
  logic        start;
  logic        is_store;
  logic [2:0]  funct3;
  logic [31:0] mem_addr;
  logic [31:0] store_data;
  logic [31:0] load_data;
  logic        done;
  logic        busy;
  logic        misaligned;
  logic        bus_err;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] ld_exp = '0;

  lsu_bus_if bus ();

  load_store_unit #(.TIMEOUT(TMO)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .is_store   (is_store),
    .funct3     (funct3),
    .mem_addr   (mem_addr),
    .store_data (store_data),
    .bus        (bus),
    .load_data  (load_data),
    .done       (done),
    .busy       (busy),
    .misaligned (misaligned),
    .bus_err    (bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #900_000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic scramble();
    is_store   = 1'($urandom);
    funct3     = 3'($urandom);
    mem_addr   = $urandom;
    store_data = $urandom;
  endtask

  // ack_at: cycle in which ack is driven (0 = never)
  task automatic run(
    input logic        st,
    input logic [2:0]  f3,
    input logic [31:0] a,
    input logic [31:0] d,
    input logic [31:0] rd,
    input int          ack_at,
    input logic        poke
  );
    int          size;
    int          cyc;
    int          req_n;
    int          stab;
    int          exp_cyc;
    int          exp_req;
    logic        legal;
    logic        ok;
    logic        tmo;
    logic        got_done;
    logic [3:0]  exp_strb;
    logic [31:0] exp_wd;
    logic [31:0] lane;
    logic [31:0] v;
    logic [31:0] waddr;

    case (f3[1:0])
      2'd0:    size = 1;
      2'd1:    size = 2;
      2'd2:    size = 4;
      default: size = 0;
    endcase
    legal = st ? (f3 < 3) : (f3 != 3 && f3 < 6);
    ok = 1'b0;
    if (legal) ok = ((a % size) == 0);
    tmo = ok && (ack_at < 1 || ack_at > TMO);
    waddr = a - (a % 4);
    exp_strb = 4'(((1 << size) - 1) << (a % 4));
    if (size == 1)      exp_wd = d[7:0] * 32'h0101_0101;
    else if (size == 2) exp_wd = d[15:0] * 32'h0001_0001;
    else                exp_wd = d;
    lane = rd >> (8 * (a % 4));
    if (size == 1) begin
      v = lane % 256;
      if (!f3[2] && v >= 128) v = v - 32'd256;
    end else if (size == 2) begin
      v = lane % 65536;
      if (!f3[2] && v >= 32768) v = v - 32'd65536;
    end else begin
      v = lane;
    end

    if (!ok)      begin exp_cyc = 1;          exp_req = 0;      end
    else if (tmo) begin exp_cyc = TMO + 1;    exp_req = TMO;    end
    else          begin exp_cyc = ack_at + 1; exp_req = ack_at; end

    start = 1'b1; is_store = st; funct3 = f3;
    mem_addr = a; store_data = d;
    @(negedge clk);
    start = 1'b0;
    scramble();
    cyc = 1;
    if (ok) begin
      check("bus_addr", bus.addr, waddr);
      check("bus_we", 32'(bus.we), 32'(st));
      check("bus_wstrb", 32'(bus.wstrb), 32'(exp_strb));
      if (st) check("bus_wdata", bus.wdata, exp_wd);
    end

    req_n = 0; stab = 0; got_done = 1'b0;
    while (cyc < TMO + 20) begin
      if (done) begin
        got_done = 1'b1;
        break;
      end
      if (bus.req) begin
        req_n++;
        if (bus.addr !== waddr || bus.wstrb !== exp_strb ||
            bus.we !== st || (st && bus.wdata !== exp_wd))
          stab++;
      end
      if (poke && cyc == 2) begin
        start = 1'b1;
        mem_addr = $urandom;
      end
      bus.ack   = (cyc == ack_at);
      bus.rdata = bus.ack ? rd : $urandom;
      @(negedge clk);
      cyc++;
      start   = 1'b0;
      bus.ack = 1'b0;
    end

    check("done_cycle", 32'(cyc), 32'(exp_cyc));
    check("req_cycles", 32'(req_n), 32'(exp_req));
    check("bus_stable", 32'(stab), 32'd0);
    if (got_done) begin
      check("req_at_done", 32'(bus.req), 32'd0);
      check("misaligned", 32'(misaligned), 32'(!ok));
      check("bus_err", 32'(bus_err), 32'(tmo));
      if (ok && !tmo && !st) ld_exp = v;
      check("load_data", load_data, ld_exp);
    end

    @(negedge clk);
    check("done_pulse", 32'(done), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_flags", 32'({misaligned, bus_err}), 32'd0);
    bus.ack = 1'b1;
    bus.rdata = $urandom;
    @(negedge clk);
    bus.ack = 1'b0;
    check("idle_ack_ld", load_data, ld_exp);
    check("idle_ack_st", 32'({busy, bus.req, done}), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    is_store = 1'b0;
    funct3 = '0;
    mem_addr = '0;
    store_data = '0;
    bus.ack = 1'b0;
    bus.rdata = '0;
    repeat (2) @(negedge clk);
    check("rst_ctrl", 32'({bus.req, done, busy, misaligned, bus_err}), 32'd0);
    check("rst_bus", 32'({bus.we, bus.wstrb}), 32'd0);
    check("rst_addr", bus.addr, 32'd0);
    check("rst_wdata", bus.wdata, 32'd0);
    check("rst_load", load_data, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run(1'b1, 3'b010, 32'h100, 32'hDEAD_BEEF, $urandom, 3, 1'b0);
    run(1'b0, 3'b000, 32'h203, $urandom, 32'h80FF_1234, 2, 1'b0);
    check("lb_sext", load_data, 32'hFFFF_FF80);
    run(1'b0, 3'b100, 32'h203, $urandom, 32'h80FF_1234, 1, 1'b0);
    check("lbu_zext", load_data, 32'h0000_0080);
    run(1'b1, 3'b001, 32'h42, 32'h0000_ABCD, $urandom, 1, 1'b0);
    run(1'b0, 3'b001, 32'h41, $urandom, $urandom, 1, 1'b0);
    run(1'b1, 3'b011, 32'h40, $urandom, $urandom, 1, 1'b0);
    run(1'b0, 3'b010, 32'h300, $urandom, $urandom, 0, 1'b0);
    run(1'b0, 3'b010, 32'h304, $urandom, 32'h1234_5678, TMO, 1'b0);
    run(1'b0, 3'b010, 32'h400, $urandom, $urandom, 4, 1'b1);

    // reset while the request is outstanding
    start = 1'b1; is_store = 1'b0;
    funct3 = 3'b010; mem_addr = 32'h500;
    @(negedge clk);
    start = 1'b0;
    check("pre_rst_req", 32'(bus.req), 32'd1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst", 32'({bus.req, done, busy}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    ld_exp = '0;
    @(negedge clk);
    check("post_rst", 32'({bus.req, done, busy}), 32'd0);
    check("post_rst_ld", load_data, ld_exp);

    for (int i = 0; i < 40; i++) begin
      logic [31:0] a;
      int          r;
      a = $urandom;
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      r = $urandom_range(0, 9);
      run(1'($urandom), 3'($urandom_range(0, 7)), a,
          $urandom, $urandom, r, ($urandom_range(0, 3) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
